// File: rtl/debug_unit_if.sv
// debug_unit_if: UART, CPU-control and dump bus of the debug unit.
// Signals:
//   rx_data/rx_done          received UART byte and its one-cycle valid pulse
//   tx_Data/tx_start/tx_done byte to send, send request, transmit-complete pulse
//   halt_flag/current_PC/clock_count  CPU status
//   IM_Addr/IM_Data/IM_We    instruction memory write port
//   RB_Addr/RB_Data          register bank read port (data one cycle after address)
//   DM_Addr/DM_Data          data memory read port (data one cycle after address)
//   clock_enable/o_rst       CPU clock enable and active-high CPU reset
// Modports: master = debug unit, slave = UART/CPU side.
interface debug_unit_if #(
    parameter int NBITS     = 32,
    parameter int BYTE      = 8,
    parameter int IM_ADDR_W = 8,
    parameter int DM_ADDR_W = 5,
    parameter int RBITS     = 5
);
    logic [BYTE-1:0]      rx_data;
    logic                 rx_done;
    logic                 tx_done;
    logic                 halt_flag;
    logic [NBITS-1:0]     current_PC;
    logic [NBITS-1:0]     clock_count;
    logic [NBITS-1:0]     RB_Data;
    logic [NBITS-1:0]     DM_Data;
    logic [IM_ADDR_W-1:0] IM_Addr;
    logic [NBITS-1:0]     IM_Data;
    logic                 IM_We;
    logic [RBITS-1:0]     RB_Addr;
    logic [DM_ADDR_W-1:0] DM_Addr;
    logic [BYTE-1:0]      tx_Data;
    logic                 tx_start;
    logic                 clock_enable;
    logic                 o_rst;

    modport master (
        input  rx_data, rx_done, tx_done, halt_flag, current_PC, clock_count, RB_Data, DM_Data,
        output IM_Addr, IM_Data, IM_We, RB_Addr, DM_Addr, tx_Data, tx_start, clock_enable, o_rst
    );
    modport slave (
        output rx_data, rx_done, tx_done, halt_flag, current_PC, clock_count, RB_Data, DM_Data,
        input  IM_Addr, IM_Data, IM_We, RB_Addr, DM_Addr, tx_Data, tx_start, clock_enable, o_rst
    );
endinterface

// File: rtl/debug_unit.sv
// debug_unit: UART-driven program loader, run/step controller and state dumper for a CPU.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    debug_unit_if.master (UART bytes, CPU status, IM write, RB/DM read, CPU control)
// Commands in IDLE: 'L' load program, 'C' run until halt, 'S' single step, 'D' dump.
// Optional macro BREAKPOINT_EN adds 'B' (load a breakpoint PC) and a PC-match exit from RUN.
module debug_unit #(
    parameter int NBITS     = 32,
    parameter int BYTE      = 8,
    parameter int IM_DEPTH  = 256,
    parameter int DM_DEPTH  = 32,
    parameter int BANK_SIZE = 32,
    parameter int IM_ADDR_W = 8,
    parameter int DM_ADDR_W = 5,
    parameter int RBITS     = 5
) (
    input logic         clk,
    input logic         reset,
    debug_unit_if.master bus
);
    localparam int NB     = NBITS / BYTE;
    localparam int BW     = $clog2(NB);
    localparam int NWORDS = 2 + BANK_SIZE + DM_DEPTH;
    localparam int DW     = $clog2(NWORDS);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOAD       = 3'd1;
    localparam logic [2:0] WRITE      = 3'd2;
    localparam logic [2:0] RUN        = 3'd3;
    localparam logic [2:0] STEP       = 3'd4;
    localparam logic [2:0] DUMP_SETUP = 3'd5;
    localparam logic [2:0] DUMP_WAIT  = 3'd6;
    localparam logic [2:0] DUMP_TX    = 3'd7;

    localparam logic [BYTE-1:0] CMD_L = BYTE'('h4C);
    localparam logic [BYTE-1:0] CMD_C = BYTE'('h43);
    localparam logic [BYTE-1:0] CMD_S = BYTE'('h53);
    localparam logic [BYTE-1:0] CMD_D = BYTE'('h44);

    localparam logic [IM_ADDR_W:0] IM_LAST   = (IM_ADDR_W + 1)'(IM_DEPTH - 1);
    localparam logic [BW-1:0]      BYTE_LAST = BW'(NB - 1);
    localparam logic [DW-1:0]      WORD_LAST = DW'(NWORDS - 1);
    localparam logic [DW-1:0]      RB_FIRST  = DW'(2);
    localparam logic [DW-1:0]      DM_FIRST  = DW'(2 + BANK_SIZE);

    logic [2:0]         state;
    logic [NBITS-1:0]   word;
    logic [NBITS-1:0]   tx_word;
    logic [BW-1:0]      byte_cnt;
    logic [IM_ADDR_W:0] wr_idx;
    logic [DW-1:0]      dump_idx;
    logic               pending;
    logic               halted;
    logic               o_rst_q;

`ifdef BREAKPOINT_EN
    logic [NBITS-1:0]   bp;
    logic               bp_valid;
    logic               bp_load;
`endif

    logic [NBITS-1:0]   nxt_word;
    logic [NBITS-1:0]   dump_word;
    logic               last_byte;
    logic               in_rb;
    logic               in_dm;
    logic               wr_done;
    logic               run_exit;

    // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
    assign nxt_word  = {bus.rx_data, word[NBITS-1:BYTE]};
    assign last_byte = byte_cnt == BYTE_LAST;
    assign in_rb     = dump_idx >= RB_FIRST && dump_idx < DM_FIRST;
    assign in_dm     = dump_idx >= DM_FIRST;
    assign wr_done   = word == '1 || wr_idx == IM_LAST;
    assign dump_word = dump_idx == '0 ? bus.current_PC :
                       dump_idx == DW'(1) ? bus.clock_count :
                       in_rb ? bus.RB_Data : bus.DM_Data;
`ifdef BREAKPOINT_EN
    assign run_exit  = bus.halt_flag || (bp_valid && bus.current_PC == bp);
`else
    assign run_exit  = bus.halt_flag;
`endif

    // Strobes decode straight from state so a reset kills them in the same instant.
    assign bus.IM_We        = state == WRITE;
    assign bus.IM_Addr      = wr_idx[IM_ADDR_W] ? '1 : wr_idx[IM_ADDR_W-1:0];
    assign bus.IM_Data      = word;
    assign bus.RB_Addr      = in_rb ? RBITS'(dump_idx - RB_FIRST) : '0;
    assign bus.DM_Addr      = in_dm ? DM_ADDR_W'(dump_idx - DM_FIRST) : '0;
    assign bus.tx_Data      = tx_word[BYTE-1:0];
    assign bus.tx_start     = state == DUMP_TX && !pending;
    assign bus.clock_enable = state == RUN || state == STEP;
    assign bus.o_rst        = o_rst_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            word     <= '0;
            tx_word  <= '0;
            byte_cnt <= '0;
            wr_idx   <= '0;
            dump_idx <= '0;
            pending  <= 1'b0;
            halted   <= 1'b0;
            o_rst_q  <= 1'b1;
`ifdef BREAKPOINT_EN
            bp       <= '0;
            bp_valid <= 1'b0;
            bp_load  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.rx_done) begin
                    if (bus.rx_data == CMD_L) begin
                        state    <= LOAD;
                        wr_idx   <= '0;
                        byte_cnt <= '0;
                        o_rst_q  <= 1'b1;
                        halted   <= 1'b0;
`ifdef BREAKPOINT_EN
                        bp_valid <= 1'b0;
`endif
                    end else if (bus.rx_data == CMD_C && !halted) state <= RUN;
                    else if (bus.rx_data == CMD_S && !halted) state <= STEP;
                    else if (bus.rx_data == CMD_D) state <= DUMP_SETUP;
`ifdef BREAKPOINT_EN
                    else if (bus.rx_data == BYTE'('h42)) begin
                        state    <= LOAD;
                        byte_cnt <= '0;
                        bp_load  <= 1'b1;
                    end
`endif
                end
                LOAD: if (bus.rx_done) begin
                    word     <= nxt_word;
                    byte_cnt <= byte_cnt + 1'b1;
`ifdef BREAKPOINT_EN
                    if (last_byte && bp_load) begin
                        bp       <= nxt_word;
                        bp_valid <= 1'b1;
                        bp_load  <= 1'b0;
                        state    <= IDLE;
                    end else if (last_byte) state <= WRITE;
`else
                    if (last_byte) state <= WRITE;
`endif
                end
                WRITE: begin
                    wr_idx <= wr_idx + 1'b1;
                    state  <= wr_done ? IDLE : LOAD;
                    if (wr_done) o_rst_q <= 1'b0;
                end
                RUN: if (run_exit) state <= DUMP_SETUP;
                STEP: state <= DUMP_SETUP;
                DUMP_SETUP: state <= DUMP_WAIT;
                DUMP_WAIT: begin
                    tx_word  <= dump_word;
                    byte_cnt <= '0;
                    state    <= DUMP_TX;
                end
                DUMP_TX: if (!pending) pending <= 1'b1;
                else if (bus.tx_done) begin
                    pending  <= 1'b0;
                    tx_word  <= tx_word >> BYTE;
                    byte_cnt <= byte_cnt + 1'b1;
                    if (last_byte && dump_idx == WORD_LAST) begin
                        dump_idx <= '0;
                        halted   <= halted | bus.halt_flag;
                        state    <= IDLE;
                    end else if (last_byte) begin
                        dump_idx <= dump_idx + 1'b1;
                        state    <= DUMP_SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: directed self-checking bench for debug_unit with UART/CPU models.
module tb_debug_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        halt_flag;
    logic [31:0] pc = 32'h40;
    logic [31:0] pc_base = 32'h40;
    bit          pc_auto = 1'b0;
    logic [31:0] rb_q = '0;
    logic [31:0] dm_q = '0;
    logic        mon_done = 1'b0;

    debug_unit_if bus();

    debug_unit dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.rx_data     = rx_data;
    assign bus.rx_done     = rx_done;
    assign bus.tx_done     = mon_done;
    assign bus.halt_flag   = halt_flag;
    assign bus.current_PC  = pc;
    assign bus.clock_count = 32'h1234_5678;
    assign bus.RB_Data     = rb_q;
    assign bus.DM_Data     = dm_q;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  txq[$];
    logic [7:0]  we_addr[$];
    logic [31:0] we_data[$];
    int tx_cnt = 0, ce_cnt = 0, we_cnt = 0, overlap = 0, dly = 0;
    bit outst = 1'b0;

    // CPU memories (registered read), UART transmitter with 4-cycle latency, PC model.
    always @(posedge clk) begin
        rb_q <= 32'hA000_0000 | {27'b0, bus.RB_Addr};
        dm_q <= 32'hD000_0000 | {27'b0, bus.DM_Addr};
        mon_done <= 1'b0;
        pc <= pc_auto ? (bus.clock_enable ? pc + 1 : pc) : pc_base;
        if (bus.clock_enable) ce_cnt++;
        if (bus.IM_We) begin
            we_cnt++;
            we_addr.push_back(bus.IM_Addr);
            we_data.push_back(bus.IM_Data);
        end
        if (bus.tx_start) begin
            if (outst) overlap++;
            txq.push_back(bus.tx_Data);
            tx_cnt++;
            outst = 1'b1;
            dly = 3;
        end else if (outst) begin
            if (dly == 0) begin
                mon_done <= 1'b1;
                outst = 1'b0;
            end else dly--;
        end
    end

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pcv);
        int w;
        logic [31:0] v;
        w = k / 4;
        v = w == 0 ? pcv : w == 1 ? 32'h1234_5678 :
            w < 34 ? (32'hA000_0000 | 32'(w - 2)) : (32'hD000_0000 | 32'(w - 34));
        return v[8*(k%4) +: 8];
    endfunction

    function automatic int dump_bad(input int base, input logic [31:0] pcv);
        int bad = 0;
        for (int k = 0; k < 264; k++)
            if (txq.size() <= base + k || txq[base+k] !== exp_byte(k, pcv)) bad++;
        return bad;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_tx(input int target, output bit timeout);
        int t = 0;
        while (tx_cnt < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        timeout = tx_cnt < target;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        n_chk++;
        if (bus.o_rst !== 1'b1) begin n_fail++; $display("FAIL reset_o_rst: got %b expected 1", bus.o_rst); end
        n_chk++;
        if ({bus.IM_We, bus.tx_start, bus.clock_enable} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000", {bus.IM_We, bus.tx_start, bus.clock_enable});
        end
        n_chk++;
        if ({bus.IM_Addr, bus.RB_Addr, bus.DM_Addr, bus.tx_Data} !== 26'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 0", {bus.IM_Addr, bus.RB_Addr, bus.DM_Addr, bus.tx_Data});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.o_rst !== 1'b1) begin n_fail++; $display("FAIL reset_release_o_rst: got %b expected 1", bus.o_rst); end
    endtask

    task automatic test_load;
        send_byte(8'h4C);
        n_chk++;
        if (bus.o_rst !== 1'b1) begin n_fail++; $display("FAIL load_o_rst_high: got %b expected 1", bus.o_rst); end
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        n_chk++;
        if (we_cnt !== 2) begin n_fail++; $display("FAIL load_we_count: got %0d expected 2", we_cnt); end
        n_chk++;
        if ({we_addr[0], we_data[0]} !== {8'h00, 32'h2001_0005}) begin
            n_fail++; $display("FAIL load_word0: got %h expected 0020010005", {we_addr[0], we_data[0]});
        end
        n_chk++;
        if ({we_addr[1], we_data[1]} !== {8'h01, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL load_word1: got %h expected 01ffffffff", {we_addr[1], we_data[1]});
        end
        n_chk++;
        if (bus.o_rst !== 1'b0) begin n_fail++; $display("FAIL load_o_rst_low: got %b expected 0", bus.o_rst); end
    endtask

    task automatic test_unknown;
        int ce0 = ce_cnt, tx0 = tx_cnt, we0 = we_cnt;
        send_byte(8'h7A);
        repeat (5) @(negedge clk);
        n_chk++;
        if ({ce_cnt - ce0, tx_cnt - tx0, we_cnt - we0} !== 96'h0 || bus.o_rst !== 1'b0) begin
            n_fail++; $display("FAIL unknown_cmd: got ce %0d tx %0d we %0d o_rst %b expected 0 0 0 0",
                               ce_cnt - ce0, tx_cnt - tx0, we_cnt - we0, bus.o_rst);
        end
    endtask

    task automatic test_run_dump;
        int ce0 = ce_cnt, tx0 = tx_cnt, we0 = we_cnt, t = 0;
        bit to;
        send_byte(8'h43);
        while (ce_cnt - ce0 < 9 && t < 100) begin @(negedge clk); t++; end
        halt_flag = 1'b1;
        t = 0;
        while (tx_cnt - tx0 < 20 && t < 1000) begin @(negedge clk); t++; end
        send_byte(8'h4C);
        send_byte(8'h53);
        send_byte(8'h7A);
        wait_tx(tx0 + 264, to);
        n_chk++;
        if (to) begin n_fail++; $display("FAIL run_timeout: got %0d bytes expected 264", tx_cnt - tx0); end
        n_chk++;
        if (ce_cnt - ce0 !== 10) begin n_fail++; $display("FAIL run_ce_cycles: got %0d expected 10", ce_cnt - ce0); end
        n_chk++;
        if (tx_cnt - tx0 !== 264) begin n_fail++; $display("FAIL run_byte_count: got %0d expected 264", tx_cnt - tx0); end
        n_chk++;
        if (txq[tx0] !== 8'h40) begin n_fail++; $display("FAIL run_first_byte: got %h expected 40", txq[tx0]); end
        n_chk++;
        if (dump_bad(tx0, 32'h40) !== 0) begin n_fail++; $display("FAIL run_dump_bytes: got %0d bad bytes expected 0", dump_bad(tx0, 32'h40)); end
        n_chk++;
        if (we_cnt !== we0 || bus.o_rst !== 1'b0 || bus.clock_enable !== 1'b0) begin
            n_fail++; $display("FAIL run_rx_ignored: got we %0d o_rst %b ce %b expected %0d 0 0", we_cnt, bus.o_rst, bus.clock_enable, we0);
        end
        n_chk++;
        if (overlap !== 0) begin n_fail++; $display("FAIL run_tx_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_halted;
        int ce0 = ce_cnt, tx0 = tx_cnt;
        send_byte(8'h43);
        send_byte(8'h53);
        repeat (10) @(negedge clk);
        n_chk++;
        if (ce_cnt !== ce0 || tx_cnt !== tx0) begin
            n_fail++; $display("FAIL halted_ignore: got ce %0d tx %0d expected 0 0", ce_cnt - ce0, tx_cnt - tx0);
        end
        halt_flag = 1'b0;
    endtask

    task automatic test_step;
        int we0 = we_cnt;
        bit to;
        send_byte(8'h4C);
        send_word(32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        n_chk++;
        if (we_cnt - we0 !== 1 || we_addr[we0] !== 8'h00) begin
            n_fail++; $display("FAIL step_reload: got %0d writes addr %h expected 1 00", we_cnt - we0, we_addr[we0]);
        end
        for (int r = 0; r < 2; r++) begin
            int ce0 = ce_cnt, tx0 = tx_cnt;
            send_byte(8'h53);
            wait_tx(tx0 + 264, to);
            n_chk++;
            if (to || tx_cnt - tx0 !== 264) begin n_fail++; $display("FAIL step%0d_byte_count: got %0d expected 264", r, tx_cnt - tx0); end
            n_chk++;
            if (ce_cnt - ce0 !== 1) begin n_fail++; $display("FAIL step%0d_ce_cycles: got %0d expected 1", r, ce_cnt - ce0); end
            n_chk++;
            if (dump_bad(tx0, 32'h40) !== 0) begin n_fail++; $display("FAIL step%0d_dump_bytes: got %0d bad expected 0", r, dump_bad(tx0, 32'h40)); end
        end
    endtask

    task automatic test_load_full;
        int we0 = we_cnt, ce0, tx0;
        bit to;
        send_byte(8'h4C);
        for (int i = 0; i < 256; i++) send_word(32'h0100_0000 + i);
        repeat (3) @(negedge clk);
        n_chk++;
        if (we_cnt - we0 !== 256) begin n_fail++; $display("FAIL full_we_count: got %0d expected 256", we_cnt - we0); end
        n_chk++;
        if ({we_addr[we_cnt-1], we_data[we_cnt-1]} !== {8'hFF, 32'h0100_00FF}) begin
            n_fail++; $display("FAIL full_last_write: got %h expected ff010000ff", {we_addr[we_cnt-1], we_data[we_cnt-1]});
        end
        n_chk++;
        if (bus.o_rst !== 1'b0) begin n_fail++; $display("FAIL full_o_rst: got %b expected 0", bus.o_rst); end
        ce0 = ce_cnt;
        tx0 = tx_cnt;
        send_byte(8'h53);
        wait_tx(tx0 + 264, to);
        n_chk++;
        if (to || ce_cnt - ce0 !== 1 || we_cnt - we0 !== 256) begin
            n_fail++; $display("FAIL full_back_to_idle: got ce %0d writes %0d expected 1 256", ce_cnt - ce0, we_cnt - we0);
        end
    endtask

    task automatic test_b_command;
        int ce0, tx0;
        bit to;
`ifdef BREAKPOINT_EN
        pc_base = 32'h0;
        repeat (2) @(negedge clk);
        send_byte(8'h42);
        send_word(32'h0000_0008);
        pc_auto = 1'b1;
        ce0 = ce_cnt;
        tx0 = tx_cnt;
        send_byte(8'h43);
        wait_tx(tx0 + 264, to);
        n_chk++;
        if (to || ce_cnt - ce0 !== 9) begin n_fail++; $display("FAIL bp_ce_cycles: got %0d expected 9", ce_cnt - ce0); end
        n_chk++;
        if (dump_bad(tx0, 32'd9) !== 0) begin n_fail++; $display("FAIL bp_dump_bytes: got %0d bad expected 0", dump_bad(tx0, 32'd9)); end
        pc_auto = 1'b0;
        pc_base = 32'h40;
        repeat (2) @(negedge clk);
`else
        ce0 = ce_cnt;
        tx0 = tx_cnt;
        send_byte(8'h42);
        send_byte(8'h53);
        wait_tx(tx0 + 264, to);
        n_chk++;
        if (to || ce_cnt - ce0 !== 1 || tx_cnt - tx0 !== 264) begin
            n_fail++; $display("FAIL b_unknown: got ce %0d tx %0d expected 1 264", ce_cnt - ce0, tx_cnt - tx0);
        end
`endif
    endtask

    task automatic test_reset_mid_dump;
        int tx0 = tx_cnt, t = 0;
        send_byte(8'h53);
        while (tx_cnt - tx0 < 100 && t < 5000) begin @(negedge clk); t++; end
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.tx_start !== 1'b0 || bus.o_rst !== 1'b1) begin
            n_fail++; $display("FAIL mid_dump_reset: got tx_start %b o_rst %b expected 0 1", bus.tx_start, bus.o_rst);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (400) @(negedge clk);
        n_chk++;
        if (tx_cnt - tx0 !== 100) begin n_fail++; $display("FAIL mid_dump_no_more_tx: got %0d expected 100", tx_cnt - tx0); end
        n_chk++;
        if (overlap !== 0) begin n_fail++; $display("FAIL final_tx_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_reset_mid_load;
        int we0;
        send_byte(8'h4C);
        send_byte(8'h11);
        send_byte(8'h22);
        we0 = we_cnt;
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.o_rst !== 1'b1 || bus.IM_We !== 1'b0) begin
            n_fail++; $display("FAIL mid_load_reset: got o_rst %b IM_We %b expected 1 0", bus.o_rst, bus.IM_We);
        end
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (5) @(negedge clk);
        n_chk++;
        if (we_cnt !== we0) begin n_fail++; $display("FAIL mid_load_no_write: got %0d writes expected 0", we_cnt - we0); end
    endtask

    initial begin
        reset = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        halt_flag = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_load;
        test_unknown;
        test_run_dump;
        test_halted;
        test_step;
        test_load_full;
        test_b_command;
        test_reset_mid_dump;
        test_reset_mid_load;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
